fifo_same_clock_fill: RTL and testbench
=======================================

// Module: fifo_same_clock_fill
// PURPOSE
//  Single-clock, parametrised FIFO for paths with no clock crossing (command queues, sequencer buffers).
//  Exact fill count. Exact full, almost_full and half_empty flags.
//  Selectable first-word-fall-through (FWFT) or registered-read mode.
//  Sticky overflow and underflow error flags.
// PARAMETERS
//  DATA_WIDTH   16  data word width, >=1
//  DATA_DEPTH    4  log2 of entry count (2^DATA_DEPTH words), >=2
//  AFULL_MARGIN  2  almost_full when fill >= 2^DATA_DEPTH - AFULL_MARGIN; legal range 1..2^DATA_DEPTH-1
//  FWFT          1  1: head word visible on data_out while nempty; 0: data_out registered, updated after re
// PORTS
//  clk         in   1             clock, positive edge; every register uses it
//  rst_n       in   1             reset, synchronous, active low
//  we          in   1             write enable
//  re          in   1             read enable
//  data_in     in   DATA_WIDTH    write data
//  data_out    out  DATA_WIDTH    read data (see BEHAVIOUR for timing)
//  nempty      out  1             FIFO holds >=1 word
//  full        out  1             fill == 2^DATA_DEPTH
//  almost_full out  1             fill >= 2^DATA_DEPTH - AFULL_MARGIN
//  half_empty  out  1             fill <= 2^(DATA_DEPTH-1), exact
//  fill        out  DATA_DEPTH+1  number of stored words
//  over        out  1             sticky: a write was rejected
//  under       out  1             sticky: a read was rejected
//  clr_err     in   1             clears over/under on the next edge
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - waddr/raddr <= 0, fill <= 0, nempty/full/almost_full/over/under <= 0, half_empty <= 1.
//   - FWFT=0: data_out <= 0.
//   - RAM contents are not cleared. we/re are ignored during the reset edge.
//   - Reset mid-operation discards all contents.
//  Acceptance, evaluated from registered state at each edge:
//   - rd_acc = re & nempty.
//   - wr_acc = we & (~full | rd_acc). At full, a simultaneous read and write are both accepted; fill is unchanged.
//   - At empty, with we&re: the write is accepted and the read is rejected (under sets); fill becomes 1.
//  Pointers:
//   - waddr/raddr are DATA_DEPTH bits and wrap 2^DATA_DEPTH-1 -> 0 naturally.
//   - fill = fill + wr_acc - rd_acc, DATA_DEPTH+1 bits. fill never exceeds 2^DATA_DEPTH and never goes negative.
//  Flags:
//   - All flags are registered, computed from the next-state fill, and update on the same edge as fill.
//   - Write at edge N -> nempty=1 and fill=1 after edge N (zero-bubble).
//  FWFT=1:
//   - data_out = ram[raddr] (asynchronous RAM read).
//   - Valid whenever nempty=1; don't-care when nempty=0.
//   - An accepted re advances to the next word after the edge.
//  FWFT=0:
//   - On rd_acc, data_out <= ram[raddr] at that edge; the data is visible the cycle after re.
//   - Otherwise data_out holds its value.
//  Errors:
//   - over <= 1 on we & ~wr_acc. under <= 1 on re & ~rd_acc.
//   - Set has priority over clr_err in the same cycle.
//   - Rejected accesses change no other state.
// STRUCTURE
//  No typedefs needed. A shared constants header provides the clog2 function used by instantiators to size DATA_DEPTH.
//  One sub-module: fifo_ram_sdp
//   - Simple dual-port 2^DATA_DEPTH x DATA_WIDTH array.
//   - Synchronous write port.
//   - Read port is asynchronous or registered, selected by parameter REG_OUT = ~FWFT.
//  Top level: pointers, fill counter, flag registers, error logic.
// TESTING
//  1 Reset then idle: fill=0, nempty=0, full=0, almost_full=0, half_empty=1, over=under=0; data_out=0 when FWFT=0.
//  2 Defaults (D=4): write 0x0001..0x0010 in 16 consecutive cycles.
//    - fill steps 1..16; almost_full rises at fill=14; half_empty falls at fill=9; full at 16.
//    - A 17th write sets over; fill stays 16.
//  3 Full, then we&re for 8 cycles writing 0x0100..0x0107.
//    - Both are accepted every cycle; fill stays 16; full stays 1.
//    - Reads return 0x0001..0x0008 in order (FWFT=0 data lags re by one cycle).
//  4 Empty, we&re with data_in=0xBEEF.
//    - under=1, fill=1, nempty=1; FWFT=1: data_out=0xBEEF the next cycle.
//    - clr_err pulse clears under; over unaffected.
//  5 Wrap: 40 words streamed with a random we/re mix (scoreboard).
//    - Pointers wrap at least twice; output order matches input; fill always equals the model count.
//  6 rst_n=0 for one edge with fill=5 and we=1.
//    - After the edge fill=0, nempty=0, write dropped; next write 0xA5A5 is the first word read.

Source files
------------

// File: rtl/fifo_same_clock_fill_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_same_clock_fill_pkg;

  // Smallest depth exponent that still leaves a meaningful half/almost-full split.
  localparam int unsigned FIFO_MIN_DEPTH = 2;

  // Ceiling log2, used by instantiators to size DATA_DEPTH from an entry count.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage array: synchronous write, asynchronous or registered read.
module fifo_ram_sdp #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned REG_OUT    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Write port; contents are never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_read
      logic [DATA_WIDTH-1:0] rdata_q;

      // Registered read: captures the old word when read and write hit the same address.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else if (re) begin
          rdata_q <= mem_q[raddr];
        end
      end

      assign rdata = rdata_q;
    end else begin : g_async_read
      logic unused_ctrl;
      assign unused_ctrl = ^{rst_n, re};
      assign rdata       = mem_q[raddr];
    end
  endgenerate

endmodule

// File: rtl/fifo_same_clock_fill.sv
// Single-clock FIFO with exact fill count, registered level flags and sticky error flags.
module fifo_same_clock_fill
  import fifo_same_clock_fill_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DATA_DEPTH   = 4,
  parameter int unsigned AFULL_MARGIN = 2,
  parameter int unsigned FWFT         = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  nempty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  half_empty,
  output logic [DATA_DEPTH:0]   fill,
  output logic                  over,
  output logic                  under,
  input  logic                  clr_err
);

  localparam int unsigned FILL_W   = DATA_DEPTH + 1;
  localparam int unsigned WORDS    = 2**DATA_DEPTH;
  localparam logic [DATA_DEPTH:0] FULL_LVL = FILL_W'(WORDS);
  localparam logic [DATA_DEPTH:0] AF_LVL   = FILL_W'(WORDS - AFULL_MARGIN);
  localparam logic [DATA_DEPTH:0] HALF_LVL = FILL_W'(WORDS / 2);
  localparam int unsigned REG_OUT  = (FWFT == 0) ? 1 : 0;

  logic [DATA_DEPTH-1:0] waddr_q, waddr_d;
  logic [DATA_DEPTH-1:0] raddr_q, raddr_d;
  logic [DATA_DEPTH:0]   fill_q, fill_d;
  logic                  nempty_q, full_q, afull_q, hempty_q;
  logic                  over_q, over_d, under_q, under_d;
  logic                  rd_acc, wr_acc;
  logic                  ram_we, ram_re;

  // Acceptance, pointer advance, fill arithmetic and sticky error next-state.
  always_comb begin
    rd_acc  = re & nempty_q;
    wr_acc  = we & (~full_q | rd_acc);
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    fill_d  = fill_q;
    if (wr_acc) begin
      waddr_d = waddr_q + 1'b1;
    end
    if (rd_acc) begin
      raddr_d = raddr_q + 1'b1;
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    // A new error in the same cycle wins over a clear request.
    over_d  = (we & ~wr_acc) | (over_q & ~clr_err);
    under_d = (re & ~rd_acc) | (under_q & ~clr_err);
  end

  // State registers; flags are derived from next-state fill so they track fill on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waddr_q  <= '0;
      raddr_q  <= '0;
      fill_q   <= '0;
      nempty_q <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      hempty_q <= 1'b1;
      over_q   <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      fill_q   <= fill_d;
      nempty_q <= (fill_d != '0);
      full_q   <= (fill_d == FULL_LVL);
      afull_q  <= (fill_d >= AF_LVL);
      hempty_q <= (fill_d <= HALF_LVL);
      over_q   <= over_d;
      under_q  <= under_d;
    end
  end

  assign ram_we = wr_acc & rst_n;
  assign ram_re = rd_acc;

  fifo_ram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DATA_DEPTH),
    .REG_OUT    (REG_OUT)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (waddr_q),
    .wdata (data_in),
    .re    (ram_re),
    .raddr (raddr_q),
    .rdata (data_out)
  );

  assign fill        = fill_q;
  assign nempty      = nempty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign half_empty  = hempty_q;
  assign over        = over_q;
  assign under       = under_q;

endmodule

// File: tb/tb_fifo_same_clock_fill.sv
// Directed bench: one FWFT and one registered-read FIFO driven with identical stimulus.
module tb_fifo_same_clock_fill;

  logic        clk = 1'b0;
  logic        rst_n, we, re, clr_err;
  logic [15:0] data_in;

  logic [15:0] dout1, dout0;
  logic [4:0]  fill1, fill0;
  logic        ne1, fu1, af1, he1, ov1, un1;
  logic        ne0, fu0, af0, he0, ov0, un0;
  logic [10:0] st1, st0;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        we, re, clr;
    logic [15:0] din;
    logic [4:0]  fill;
    logic        nempty, full, af, he, over, under;
    logic        chk_d1;
    logic [15:0] d1;
    logic        chk_d0;
    logic [15:0] d0;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  fifo_same_clock_fill #(.DATA_WIDTH(16), .DATA_DEPTH(4), .AFULL_MARGIN(2), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .data_in(data_in), .data_out(dout1),
    .nempty(ne1), .full(fu1), .almost_full(af1), .half_empty(he1), .fill(fill1),
    .over(ov1), .under(un1), .clr_err(clr_err));

  fifo_same_clock_fill #(.DATA_WIDTH(16), .DATA_DEPTH(4), .AFULL_MARGIN(2), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .data_in(data_in), .data_out(dout0),
    .nempty(ne0), .full(fu0), .almost_full(af0), .half_empty(he0), .fill(fill0),
    .over(ov0), .under(un0), .clr_err(clr_err));

  assign st1 = {fill1, ne1, fu1, af1, he1, ov1, un1};
  assign st0 = {fill0, ne0, fu0, af0, he0, ov0, un0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_st(input string name, input logic [4:0] f, input logic ne, input logic fu,
                          input logic af, input logic he, input logic ov, input logic un);
    check({name, " state fwft1"}, 32'(st1), 32'({f, ne, fu, af, he, ov, un}));
    check({name, " state fwft0"}, 32'(st0), 32'({f, ne, fu, af, he, ov, un}));
  endtask

  task automatic drive(input logic w, input logic r, input logic c, input logic [15:0] d);
    we = w; re = r; clr_err = c; data_in = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic c, input logic [15:0] d,
                              input int f, input logic ov, input logic cd1, input logic [15:0] d1,
                              input logic cd0, input logic [15:0] d0);
    vec_t v;
    v.we = w; v.re = r; v.clr = c; v.din = d;
    v.fill   = 5'(f);
    v.nempty = (f != 0);
    v.full   = (f == 16);
    v.af     = (f >= 14);
    v.he     = (f <= 8);
    v.over   = ov;
    v.under  = 1'b0;
    v.chk_d1 = cd1; v.d1 = d1;
    v.chk_d0 = cd0; v.d0 = d0;
    return v;
  endfunction

  initial begin
    logic [15:0] drain_words [17];
    logic [15:0] sb[$];
    logic [15:0] expw;
    int written, nread, cycles;
    logic w, r, rd, wr;

    // Fill ramp: 16 writes, then a rejected 17th.
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 16'(i + 1), i + 1, 1'b0, 1'b1, 16'h0001, 1'b1, 16'h0000));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0011, 16, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0000));
    // Simultaneous read/write at full.
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'(16'h0100 + k), 16, 1'b1,
                       1'b1, 16'(k + 2), 1'b1, 16'(k + 1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0000, 16, 1'b0, 1'b1, 16'h0009, 1'b1, 16'h0008));
    // Drain the remaining 16 words.
    for (int j = 0; j < 8; j++) drain_words[j] = 16'(9 + j);
    for (int j = 0; j < 8; j++) drain_words[8 + j] = 16'(16'h0100 + j);
    drain_words[16] = 16'h0000;
    for (int j = 0; j < 16; j++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 15 - j, 1'b0,
                       (j < 15), drain_words[j + 1], 1'b1, drain_words[j]));

    // Reset then idle.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    step(); step();
    rst_n = 1'b1;
    step();
    check_st("reset", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("reset dout fwft0", 32'(dout0), 32'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].re, tbl[i].clr, tbl[i].din);
      step();
      check_st($sformatf("vec%0d", i), tbl[i].fill, tbl[i].nempty, tbl[i].full, tbl[i].af,
               tbl[i].he, tbl[i].over, tbl[i].under);
      if (tbl[i].chk_d1) check($sformatf("vec%0d dout fwft1", i), 32'(dout1), 32'(tbl[i].d1));
      if (tbl[i].chk_d0) check($sformatf("vec%0d dout fwft0", i), 32'(dout0), 32'(tbl[i].d0));
    end

    // Empty with we&re: write lands, read rejected.
    drive(1'b1, 1'b1, 1'b0, 16'hBEEF);
    step();
    check_st("empty we&re", 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("empty we&re dout fwft1", 32'(dout1), 32'h0000BEEF);
    check("empty we&re dout fwft0 hold", 32'(dout0), 32'h00000107);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    step();
    check_st("read beef", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("read beef dout fwft0", 32'(dout0), 32'h0000BEEF);
    drive(1'b0, 1'b1, 1'b1, 16'h0000);
    step();
    check_st("set beats clr", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    step();
    check_st("clr under", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random stream against a scoreboard.
    written = 0; nread = 0; cycles = 0;
    while ((written < 40 || sb.size() > 0) && cycles < 600) begin
      w  = (written < 40) && ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) != 0);
      rd = r && (sb.size() > 0);
      wr = w && ((sb.size() < 16) || rd);
      if (rd) check("stream head fwft1", 32'(dout1), 32'(sb[0]));
      drive(w, r, 1'b0, 16'(16'h5000 + written));
      step();
      if (rd) begin
        expw = sb.pop_front();
        check("stream data fwft0", 32'(dout0), 32'(expw));
        nread++;
      end
      if (wr) begin
        sb.push_back(16'(16'h5000 + written));
        written++;
      end
      check("stream fill fwft1", 32'(fill1), 32'(sb.size()));
      check("stream fill fwft0", 32'(fill0), 32'(sb.size()));
      cycles++;
    end
    check("stream completed", 32'(nread), 32'd40);
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    step();

    // Reset mid-operation with a concurrent write.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'(16'h0600 + i));
      step();
    end
    check_st("pre-reset", 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h7777);
    step();
    rst_n = 1'b1;
    check_st("mid reset", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("mid reset dout fwft0", 32'(dout0), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 16'hA5A5);
    step();
    check_st("post reset write", 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("post reset head fwft1", 32'(dout1), 32'h0000A5A5);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    step();
    check("post reset read fwft0", 32'(dout0), 32'h0000A5A5);
    check_st("post reset drained", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
